// File: rtl/mac_head_tx_stream.sv
// mac_head_tx_stream: serialises the Ethernet MAC header (preamble/SFD, dst,
// src, optional 802.1Q tag, EtherType) onto a DATA_W-wide valid/ready stream.
// Optional feature macro: MAC_HEAD_TX_VLAN_EN inserts the 4-byte VLAN tag.
//
// state | meaning
// IDLE  | waiting for start_i, frame registers hold last frame
// SEND  | presenting header beats, counter advances on each handshake
module mac_head_tx_stream #(
    parameter int          DATA_W   = 64,
    parameter int          DATA_N   = DATA_W / 8,
    parameter logic [47:0] SRC_ADDR = 48'h000000F82F08
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [47:0]       dst_addr_i,
    input  logic [15:0]       etype_i,
    input  logic [11:0]       vid_i,
    input  logic [2:0]        pcp_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [DATA_N-1:0] keep_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

`ifdef MAC_HEAD_TX_VLAN_EN
    localparam int HEAD_N = 26;
`else
    localparam int HEAD_N = 22;
`endif
    localparam int BEATS  = (HEAD_N + DATA_N - 1) / DATA_N;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int FLAT_W = BEATS * DATA_W;
    localparam int SH_W   = $clog2(FLAT_W) + 1;
    localparam int REM    = HEAD_N % DATA_N;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEATS - 1);
    localparam logic [DATA_N-1:0] KEEP_LAST = (REM == 0) ? {DATA_N{1'b1}}
                                                         : DATA_N'((1 << REM) - 1);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             done_q;
    logic [47:0]      dst_q;
    logic [15:0]      etype_q;
`ifdef MAC_HEAD_TX_VLAN_EN
    logic [11:0]      vid_q;
    logic [2:0]       pcp_q;
`else
    logic             unused_vlan;
    assign unused_vlan = ^{vid_i, pcp_i};
`endif

    logic [FLAT_W-1:0] hdr_flat;
    logic [SH_W-1:0]   shift_amt;
    logic              at_last;

    // Frame sequencing: latch frame fields on start, advance beats on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            dst_q   <= '0;
            etype_q <= '0;
`ifdef MAC_HEAD_TX_VLAN_EN
            vid_q   <= '0;
            pcp_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        dst_q   <= dst_addr_i;
                        etype_q <= etype_i;
`ifdef MAC_HEAD_TX_VLAN_EN
                        vid_q   <= vid_i;
                        pcp_q   <= pcp_i;
`endif
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (ready_i) begin
                        if (at_last) begin
                            cnt_q   <= '0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Whole header laid out byte by byte; padding past HEAD_N stays zero
    always_comb begin
        hdr_flat = '0;
        for (int i = 0; i < 7; i++) hdr_flat[8*i +: 8] = 8'h55;
        hdr_flat[8*7 +: 8] = 8'hD5;
        for (int i = 0; i < 6; i++) begin
            hdr_flat[8*(8+i) +: 8]  = dst_q[8*(5-i) +: 8];
            hdr_flat[8*(14+i) +: 8] = SRC_ADDR[8*(5-i) +: 8];
        end
`ifdef MAC_HEAD_TX_VLAN_EN
        hdr_flat[8*20 +: 8] = 8'h81;
        hdr_flat[8*21 +: 8] = 8'h00;
        hdr_flat[8*22 +: 8] = {pcp_q, 1'b0, vid_q[11:8]};
        hdr_flat[8*23 +: 8] = vid_q[7:0];
`endif
        hdr_flat[8*(HEAD_N-2) +: 8] = etype_q[15:8];
        hdr_flat[8*(HEAD_N-1) +: 8] = etype_q[7:0];
    end

    // Beat selection depends only on registered state
    always_comb begin
        at_last   = (cnt_q == LAST_CNT);
        shift_amt = SH_W'(cnt_q) * SH_W'(DATA_W);
        data_o    = valid_q ? DATA_W'(hdr_flat >> shift_amt) : '0;
        keep_o    = !valid_q ? '0 : (at_last ? KEEP_LAST : {DATA_N{1'b1}});
        last_o    = valid_q && at_last;
    end

    assign valid_o = valid_q;
    assign busy_o  = (state_q == ST_SEND);
    assign done_o  = done_q;

endmodule

// File: doc/mac_head_tx_stream.md
# mac_head_tx_stream

Sequential Ethernet MAC header emitter for the TX path. It serialises preamble/SFD, destination address, source address, an optional 802.1Q tag and the EtherType onto a parametrised-width valid/ready stream. Destination address, EtherType and VLAN fields are latched per frame on `start_i`, so one instance can address several clients. It sits ahead of the payload mux in the TX MAC; the payload path starts streaming after `done_o`.

## Interface

**Parameters**

- `DATA_W`, default 64: output data width. Legal values are 8, 16, 32, 64 and 128.
- `DATA_N`, default `DATA_W/8`: output lanes, one byte each.
- `SRC_ADDR`, default 48'h000000F82F08: source MAC address, fixed at elaboration.

**Ports**

- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start_i` in 1: request one header. Sampled only in IDLE.
- `dst_addr_i` in 48: destination MAC. Bits [47:40] are the first byte on the wire.
- `etype_i` in 16: EtherType. Bits [15:8] are the first byte on the wire.
- `vid_i` in 12: VLAN ID. Used only under `MAC_HEAD_TX_VLAN_EN`.
- `pcp_i` in 3: priority code point. Used only under `MAC_HEAD_TX_VLAN_EN`.
- `valid_o` out 1: beat valid.
- `ready_i` in 1: downstream accepts the beat.
- `data_o` out DATA_W: beat data. Byte k of the beat is on `data_o[8k+7:8k]`, and lane 0 is first on the wire.
- `keep_o` out DATA_N: byte-valid mask.
- `last_o` out 1: final header beat.
- `busy_o` out 1: a frame is in progress.
- `done_o` out 1: one-cycle pulse after the final beat is accepted.

## Operation

**Header byte order**

- Bytes 0–6: 0x55.
- Byte 7: SFD 0xD5.
- Bytes 8–13: dst, MSB first.
- Bytes 14–19: `SRC_ADDR`, MSB first.
- With VLAN only, bytes 20–23: 0x81, 0x00, {PCP, DEI=0, VID[11:8]}, VID[7:0].
- Final two bytes: EtherType, MSB first.

**Header length**

- HEAD_N = 22 bytes, or 26 bytes with VLAN.
- BEATS = ceil(HEAD_N/DATA_N).
- Beat b carries header bytes b·DATA_N … b·DATA_N+DATA_N−1.

**State machine**

- IDLE:
  - `start_i` latches `dst_addr_i`, `etype_i`, `vid_i` and `pcp_i` into frame registers.
  - The beat counter clears to 0 and the FSM goes to SEND.
- SEND:
  - `valid_o`=1.
  - On `valid_o && ready_i`, the counter increments.
  - On the handshake with counter==BEATS−1, the FSM returns to IDLE.
- `busy_o` = (state==SEND).
- `start_i` while in SEND is ignored. Inputs changing mid-frame have no effect.

**Keep and last**

- `keep_o` is all-ones on every beat except the last.
- On the last beat, the low (HEAD_N mod DATA_N) bits are set, or all bits if the remainder is 0.
- Unkept lanes drive 0x00.
- `last_o` = `valid_o` && (counter==BEATS−1).

**Beat generation**

- `data_o`, `keep_o` and `last_o` are a combinational function of the frame registers and the counter.
- Only registered state feeds them; there is no combinational path from any input.

## Timing

- Reset (sync, takes effect at the `clk` edge with `rst`=1):
  - state=IDLE, counter=0.
  - `valid_o`=0, `last_o`=0, `busy_o`=0, `done_o`=0.
  - `data_o`=0, `keep_o`=0.
  - Frame registers reset to 0.
- Latency: `start_i` at cycle T gives `valid_o`=1 with beat 0 at T+1.
- Handshake rules:
  - Once raised, `valid_o` stays high, and `data_o`/`keep_o`/`last_o` stay stable, until `ready_i`.
  - `ready_i` may toggle arbitrarily.
  - `ready_i` while `valid_o`=0 has no effect.
- Throughput: with `ready_i` held high, the frame takes BEATS consecutive cycles.
- Done timing:
  - Last handshake at cycle N gives `done_o`=1 and `busy_o`=0 at N+1.
  - `start_i` at N+1 is accepted, giving beat 0 at N+2.
  - `start_i` at N itself is ignored.
- Reset mid-frame: the frame is aborted and the state is IDLE in the next cycle. `done_o` is not pulsed.
- DATA_W=8 with VLAN: the counter is ⌈log2(BEATS)⌉ = 5 bits wide, with no wrap beyond BEATS−1.

## Configuration

- Macro `MAC_HEAD_TX_VLAN_EN`.
- Defined:
  - HEAD_N=26 and the 4-byte 802.1Q tag is inserted before the EtherType.
  - `vid_i` and `pcp_i` are latched on `start_i`.
- Undefined:
  - HEAD_N=22 and no tag is emitted.
  - `vid_i` and `pcp_i` stay in the port list but are unused, and no registers are inferred for them.

## Test plan

- **DATA_W=64, no VLAN, dst=48'h0A0B0C0D0E0F, etype=16'h0800, `ready_i`=1:**
  - Exactly 3 beats.
  - Beat 0 = 64'hD555555555555555, keep 8'hFF.
  - Beat 1 = 64'h00000F0E0D0C0B0A, keep 8'hFF.
  - Beat 2 = 64'h00000008082FF800, keep 8'h3F, `last_o`=1.
  - `done_o` pulses one cycle later.
- **DATA_W=64, VLAN on, vid=12'h123, pcp=3'h5:**
  - 4 beats.
  - Beat 2 bytes 20–23 = 81 00 A1 23.
  - Beat 3 = 64'h0000000000000008, keep 8'h03.
- **Backpressure, DATA_W=32:**
  - Random `ready_i` with 50% low.
  - `valid_o` never drops mid-frame and data is stable while stalled.
  - 6 beats (no VLAN) complete in order.
- **Start while busy:**
  - Pulse `start_i` with a different dst during beat 1 and during the last-beat cycle.
  - Both are ignored, and the frame carries the original dst.
  - `start_i` in the `done_o` cycle yields beat 0 the next cycle.
- **Reset mid-frame, DATA_W=8:**
  - Assert `rst` at beat 10.
  - Next cycle: all outputs 0, no `done_o`.
  - A new `start_i` emits 22 beats starting at 0x55.
